// File: rtl/vend_pkg.sv
// vend_pkg: state encoding, clog2 helper and price-table slice macro shared by the vending controller.
// Rev 1.0
`default_nettype none

`define VEND_PRICE(tbl, k, w) tbl[(k)*(w) +: (w)]

package vend_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_VEND    = 2'd1,
      ST_CHANGE  = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vend_credit_acc.sv
// vend_credit_acc: credit register with overflow-checked coin add, vend subtract and change clear.
// Rev 1.0
`default_nettype none

module vend_credit_acc
   import vend_pkg::*;
#(
   parameter int AMT_W      = 8,
   parameter int MAX_CREDIT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             add_en,
   input  logic [AMT_W-1:0] add_val,
   input  logic             sub_en,
   input  logic [AMT_W-1:0] sub_val,
   input  logic             clr,
   output logic [AMT_W-1:0] credit,
   output logic             ovf
);

   localparam logic [AMT_W:0] MAX_EXT = MAX_CREDIT[AMT_W:0];

   logic [AMT_W:0] sum;

   // One extra bit so a wrapping add can never look like a small credit.
   assign sum = {1'b0, credit} + {1'b0, add_val};
   assign ovf = (sum > MAX_EXT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         credit <= '0;
      end else if (clr) begin
         credit <= '0;
      end else if (sub_en) begin
         credit <= credit - sub_val;
      end else if (add_en && !ovf) begin
         credit <= sum[AMT_W-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/multi_product_vend_ctrl.sv
// multi_product_vend_ctrl: coin-credit vending FSM for N products with price table and change handshake.
// Rev 1.0
`default_nettype none

module multi_product_vend_ctrl
   import vend_pkg::*;
#(
   parameter  int AMT_W      = 8,
   parameter  int N_PROD     = 4,
   parameter  int MAX_CREDIT = 255,
   parameter  int AUTO_VEND  = 0,
   localparam int SEL_W      = clog2(N_PROD)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    c,
   input  logic [AMT_W-1:0]        a,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    req,
   input  logic                    cancel,
   input  logic [N_PROD*AMT_W-1:0] prices,
   output logic                    d,
   output logic [SEL_W-1:0]        d_prod,
   output logic [AMT_W-1:0]        credit,
   output logic                    coin_rej,
   output logic                    req_nack,
   output logic                    chg_valid,
   output logic [AMT_W-1:0]        chg_amt,
   input  logic                    chg_ready
);

   state_t           state, state_nxt;
   logic [AMT_W-1:0] price;
   logic             ovf;
   logic             add_en, sub_en, clr;
   logic             vend_ok;
   logic             d_nxt, rej_nxt, nack_nxt, chg_valid_nxt;
   logic [SEL_W-1:0] d_prod_nxt;
   logic [AMT_W-1:0] chg_amt_nxt;

   assign price   = `VEND_PRICE(prices, sel, AMT_W);
   // Auto-vend never fires on zero credit, so a free product is only vended on an explicit req.
   assign vend_ok = (req || ((AUTO_VEND != 0) && (credit != '0))) && (credit >= price);

   vend_credit_acc #(
      .AMT_W      (AMT_W),
      .MAX_CREDIT (MAX_CREDIT)
   ) u_acc (
      .clk     (clk),
      .reset   (reset),
      .add_en  (add_en),
      .add_val (a),
      .sub_en  (sub_en),
      .sub_val (price),
      .clr     (clr),
      .credit  (credit),
      .ovf     (ovf)
   );

   always_comb begin
      state_nxt     = state;
      d_nxt         = 1'b0;
      d_prod_nxt    = '0;
      rej_nxt       = 1'b0;
      nack_nxt      = 1'b0;
      chg_valid_nxt = 1'b0;
      chg_amt_nxt   = '0;
      add_en        = 1'b0;
      sub_en        = 1'b0;
      clr           = 1'b0;
      case (state)
         ST_COLLECT: begin
            if (cancel && (credit != '0)) begin
               state_nxt     = ST_CHANGE;
               chg_valid_nxt = 1'b1;
               chg_amt_nxt   = credit;
               rej_nxt       = c;
            end else if (vend_ok) begin
               state_nxt  = ST_VEND;
               d_nxt      = 1'b1;
               d_prod_nxt = sel;
               sub_en     = 1'b1;
               rej_nxt    = c;
            end else begin
               nack_nxt = req;
               if (c) begin
                  rej_nxt = ovf;
                  add_en  = !ovf;
               end
            end
         end
         ST_VEND: begin
            if (credit != '0) begin
               state_nxt     = ST_CHANGE;
               chg_valid_nxt = 1'b1;
               chg_amt_nxt   = credit;
            end else begin
               state_nxt = ST_COLLECT;
            end
            rej_nxt  = c;
            nack_nxt = req;
         end
         ST_CHANGE: begin
            if (chg_ready) begin
               clr       = 1'b1;
               state_nxt = ST_COLLECT;
            end else begin
               chg_valid_nxt = 1'b1;
               chg_amt_nxt   = chg_amt;
            end
            rej_nxt  = c;
            nack_nxt = req;
         end
         default: state_nxt = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_COLLECT;
         d         <= 1'b0;
         d_prod    <= '0;
         coin_rej  <= 1'b0;
         req_nack  <= 1'b0;
         chg_valid <= 1'b0;
         chg_amt   <= '0;
      end else begin
         state     <= state_nxt;
         d         <= d_nxt;
         d_prod    <= d_prod_nxt;
         coin_rej  <= rej_nxt;
         req_nack  <= nack_nxt;
         chg_valid <= chg_valid_nxt;
         chg_amt   <= chg_amt_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_product_vend_ctrl.sv
// tb_multi_product_vend_ctrl: scoreboard bench driving a manual-vend and an auto-vend instance in lockstep.
// Rev 1.0
`default_nettype none

module tb_multi_product_vend_ctrl;

   localparam int PH_IDLE = 0;
   localparam int PH_VEND = 1;
   localparam int PH_CHG  = 2;
   localparam int K_D     = 0;
   localparam int K_REJ   = 1;
   localparam int K_NACK  = 2;
   localparam int K_OFFER = 3;

   typedef struct {
      int t;
      int v;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        c = 1'b0;
   logic [7:0]  a = '0;
   logic [1:0]  sel = '0;
   logic        req = 1'b0;
   logic        cancel = 1'b0;
   logic        chg_ready = 1'b0;
   logic [31:0] prices = '0;

   logic        d_o    [2];
   logic [1:0]  dp_o   [2];
   logic [7:0]  cr_o   [2];
   logic        rej_o  [2];
   logic        nack_o [2];
   logic        cv_o   [2];
   logic [7:0]  ca_o   [2];

   int   checks = 0;
   int   errors = 0;
   int   ecount = 0;
   int   ptab    [4];
   int   ptab_nx [4];
   int   m_phase [2];
   int   m_credit[2];
   ev_t  evq [8][$];
   ev_t  crq [2][$];
   logic pv  [2];
   logic [7:0] pa [2];

   always #5 clk = ~clk;
   always @(posedge clk) ecount <= ecount + 1;

   multi_product_vend_ctrl #(.AMT_W(8), .N_PROD(4), .MAX_CREDIT(255), .AUTO_VEND(0)) dut (
      .clk(clk), .reset(reset), .c(c), .a(a), .sel(sel), .req(req), .cancel(cancel),
      .prices(prices), .d(d_o[0]), .d_prod(dp_o[0]), .credit(cr_o[0]), .coin_rej(rej_o[0]),
      .req_nack(nack_o[0]), .chg_valid(cv_o[0]), .chg_amt(ca_o[0]), .chg_ready(chg_ready)
   );

   multi_product_vend_ctrl #(.AMT_W(8), .N_PROD(4), .MAX_CREDIT(255), .AUTO_VEND(1)) dut_auto (
      .clk(clk), .reset(reset), .c(c), .a(a), .sel(sel), .req(req), .cancel(cancel),
      .prices(prices), .d(d_o[1]), .d_prod(dp_o[1]), .credit(cr_o[1]), .coin_rej(rej_o[1]),
      .req_nack(nack_o[1]), .chg_valid(cv_o[1]), .chg_amt(ca_o[1]), .chg_ready(chg_ready)
   );

   task automatic push(input int idx, input int t, input int v);
      ev_t e;
      e.t = t;
      e.v = v;
      evq[idx].push_back(e);
   endtask

   // Reference: one machine cycle of the vending rules, applied to plain integers.
   task automatic model_step(input int i, input int t);
      int  p;
      bit  busy;
      bit  wants;
      p    = ptab[sel];
      busy = 1'b0;
      if (m_phase[i] == PH_IDLE) begin
         wants = req || (i == 1 && m_credit[i] > 0);
         if (cancel && m_credit[i] > 0) begin
            m_phase[i] = PH_CHG;
            push(i*4 + K_OFFER, t, m_credit[i]);
            busy = 1'b1;
         end else if (wants && m_credit[i] >= p) begin
            m_credit[i] = m_credit[i] - p;
            m_phase[i]  = PH_VEND;
            push(i*4 + K_D, t, int'(sel));
            busy = 1'b1;
         end else if (req) begin
            push(i*4 + K_NACK, t, 0);
         end
         if (c) begin
            if (busy || m_credit[i] + int'(a) > 255) push(i*4 + K_REJ, t, 0);
            else m_credit[i] = m_credit[i] + int'(a);
         end
      end else begin
         if (m_phase[i] == PH_VEND) begin
            if (m_credit[i] > 0) begin
               m_phase[i] = PH_CHG;
               push(i*4 + K_OFFER, t, m_credit[i]);
            end else begin
               m_phase[i] = PH_IDLE;
            end
         end else if (chg_ready) begin
            m_credit[i] = 0;
            m_phase[i]  = PH_IDLE;
         end
         if (c)   push(i*4 + K_REJ, t, 0);
         if (req) push(i*4 + K_NACK, t, 0);
      end
      begin
         ev_t e;
         e.t = t;
         e.v = m_credit[i];
         crq[i].push_back(e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i]  = PH_IDLE;
         m_credit[i] = 0;
         crq[i].delete();
      end
      for (int k = 0; k < 8; k++) evq[k].delete();
   endtask

   task automatic drive(input bit c_, input int a_, input int s_, input bit r_, input bit x_, input bit k_);
      for (int k = 0; k < 4; k++) ptab[k] = ptab_nx[k];
      prices    = {8'(ptab[3]), 8'(ptab[2]), 8'(ptab[1]), 8'(ptab[0])};
      c         = c_;
      a         = 8'(a_);
      sel       = 2'(s_);
      req       = r_;
      cancel    = x_;
      chg_ready = k_;
      model_step(0, ecount + 1);
      model_step(1, ecount + 1);
   endtask

   task automatic cyc(input bit c_, input int a_, input int s_, input bit r_, input bit x_, input bit k_);
      @(negedge clk);
      drive(c_, a_, s_, r_, x_, k_);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_eq(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic check_ev(input int idx, input bit obs, input int val, input string nm);
      ev_t e;
      if (obs) begin
         checks++;
         if (evq[idx].size() == 0) begin
            errors++;
            $display("FAIL %s inst%0d: unexpected output value %0d at edge %0d, required none", nm, idx/4, val, ecount);
         end else begin
            e = evq[idx].pop_front();
            if (e.t != ecount || e.v != val) begin
               errors++;
               $display("FAIL %s inst%0d: got %0d at edge %0d, required %0d at edge %0d", nm, idx/4, val, ecount, e.v, e.t);
            end
         end
      end
      while (evq[idx].size() > 0 && evq[idx][0].t <= ecount) begin
         e = evq[idx].pop_front();
         checks++;
         errors++;
         $display("FAIL %s inst%0d: no output at edge %0d, required %0d", nm, idx/4, e.t, e.v);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            ev_t e;
            checks++;
            if (crq[i].size() == 0) begin
               errors++;
               $display("FAIL credit inst%0d: got %0d at edge %0d, required no edge", i, cr_o[i], ecount);
            end else begin
               e = crq[i].pop_front();
               if (e.t != ecount || e.v != int'(cr_o[i])) begin
                  errors++;
                  $display("FAIL credit inst%0d: got %0d at edge %0d, required %0d at edge %0d", i, cr_o[i], ecount, e.v, e.t);
               end
            end
            check_ev(i*4 + K_D,     d_o[i],              int'(dp_o[i]), "dispense");
            check_ev(i*4 + K_REJ,   rej_o[i],            0,             "coin_rej");
            check_ev(i*4 + K_NACK,  nack_o[i],           0,             "req_nack");
            check_ev(i*4 + K_OFFER, cv_o[i] && !pv[i],   int'(ca_o[i]), "chg_offer");
            if (cv_o[i] && pv[i]) check_eq("chg_amt_stable", int'(ca_o[i]), int'(pa[i]));
            pv[i] = cv_o[i];
            pa[i] = ca_o[i];
         end
      end
   end

   function automatic bit req_sure(input int s);
      for (int i = 0; i < 2; i++) begin
         if (m_phase[i] == PH_IDLE && m_credit[i] < ptab_nx[s]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit cancel_sure();
      for (int i = 0; i < 2; i++) begin
         if (m_phase[i] == PH_IDLE && m_credit[i] == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   initial begin
      ptab_nx = '{10, 20, 30, 50};
      ptab    = '{10, 20, 30, 50};
      prices  = {8'd50, 8'd30, 8'd20, 8'd10};
      model_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_eq("reset_d",         int'(d_o[i]),    0);
         check_eq("reset_d_prod",    int'(dp_o[i]),   0);
         check_eq("reset_credit",    int'(cr_o[i]),   0);
         check_eq("reset_coin_rej",  int'(rej_o[i]),  0);
         check_eq("reset_req_nack",  int'(nack_o[i]), 0);
         check_eq("reset_chg_valid", int'(cv_o[i]),   0);
         check_eq("reset_chg_amt",   int'(ca_o[i]),   0);
      end
      release_reset();

      // Exact-price purchase, no change.
      cyc(1, 10, 2, 0, 0, 0);
      cyc(1, 20, 2, 0, 0, 0);
      cyc(0, 0, 2, 1, 0, 0);
      repeat (3) cyc(0, 0, 2, 0, 0, 0);
      // Purchase with change held off by the actuator.
      cyc(1, 50, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
      repeat (4) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0);
      // Credit ceiling.
      cyc(1, 200, 3, 0, 0, 0);
      cyc(1, 50, 3, 0, 0, 0);
      cyc(1, 10, 3, 0, 0, 0);
      cyc(1, 5, 3, 0, 0, 0);
      cyc(0, 0, 3, 0, 1, 0);
      cyc(0, 0, 3, 0, 0, 1);
      cyc(0, 0, 3, 0, 0, 0);
      // Refused request, then refund.
      cyc(1, 10, 3, 0, 0, 0);
      cyc(0, 0, 3, 1, 0, 0);
      cyc(0, 0, 3, 0, 1, 0);
      cyc(0, 0, 3, 0, 0, 0);
      cyc(0, 0, 3, 0, 0, 1);
      cyc(0, 0, 3, 0, 0, 0);
      // Auto-vend on the second instance; coin alongside an accepted req.
      cyc(1, 10, 2, 0, 0, 0);
      cyc(1, 20, 2, 0, 0, 0);
      repeat (2) cyc(0, 0, 2, 0, 0, 0);
      cyc(1, 10, 2, 1, 0, 0);
      repeat (2) cyc(0, 0, 2, 0, 0, 0);
      cyc(0, 0, 2, 0, 0, 1);
      cyc(0, 0, 2, 0, 0, 0);
      // Asynchronous reset while change is pending.
      cyc(1, 50, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      check_eq("pre_reset_chg_valid", int'(cv_o[0]), 1);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq("async_reset_chg_valid", int'(cv_o[i]), 0);
         check_eq("async_reset_credit",    int'(cr_o[i]), 0);
         check_eq("async_reset_d",         int'(d_o[i]),  0);
      end
      model_reset();
      c = 1'b0; req = 1'b0; cancel = 1'b0; chg_ready = 1'b0;
      @(negedge clk);
      release_reset();
      cyc(1, 10, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 1);

      for (int n = 0; n < 1500; n++) begin
         int r, s, av;
         bit cc, rr, xx, kk;
         if (n >= 700 && n % 60 == 0) begin
            for (int k = 0; k < 4; k++) ptab_nx[k] = $urandom_range(0, 80);
         end
         r  = $urandom_range(0, 99);
         s  = $urandom_range(0, 3);
         av = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : 5 * $urandom_range(0, 10);
         kk = ($urandom_range(0, 2) == 0);
         cc = 1'b0; rr = 1'b0; xx = 1'b0;
         if (r < 40) begin
            cc = 1'b1;
         end else if (r < 55) begin
            rr = 1'b1;
         end else if (r < 62) begin
            xx = 1'b1;
         end else if (r < 70) begin
            rr = 1'b1;
            cc = req_sure(s);
         end else if (r < 74) begin
            xx = 1'b1;
            cc = cancel_sure();
         end
         cyc(cc, av, s, rr, xx, kk);
      end
      repeat (5) cyc(0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #3;
      for (int k = 0; k < 8; k++) check_eq("leftover_events", evq[k].size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
